// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: width defaults, opcode constants and
// the sequencer FSM state type.
package cpu_pkg;

    // Default widths of the core datapath
    localparam int unsigned PcWidthDef      = 8;
    localparam int unsigned ProgramWidthDef = 16;
    localparam int unsigned ParamBitsDef    = 8;
    localparam int unsigned RetireBitsDef   = 16;

    // Opcode field values as produced/consumed by the decoder
    localparam logic [3:0] Op_NOP  = 4'h0;
    localparam logic [3:0] Op_MOV  = 4'h1;
    localparam logic [3:0] Op_ADD  = 4'h2;
    localparam logic [3:0] Op_SUB  = 4'h3;
    localparam logic [3:0] Op_AND  = 4'h4;
    localparam logic [3:0] Op_OR   = 4'h5;
    localparam logic [3:0] Op_XOR  = 4'h6;
    localparam logic [3:0] Op_GOTO = 4'h7;
    localparam logic [3:0] Op_IFZ  = 4'h8;
    localparam logic [3:0] Op_IFNZ = 4'h9;
    localparam logic [3:0] Op_IFGT = 4'hA;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        EXEC   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter with next-PC selection: increment, absolute load or
// relative branch by a sign-extended offset. Arithmetic wraps modulo 2^PC_WIDTH.
module pc_unit #(
    parameter int unsigned PC_WIDTH  = 8,
    parameter int unsigned ParamBits = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 cnt_wr_en,
    input  logic                 add_offset,
    input  logic [ParamBits-1:0] literal,
    output logic [PC_WIDTH-1:0]  pc
);

    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_next;

    // Select the next program counter value
    always_comb begin
        offset_ext = PC_WIDTH'($signed(literal));
        target     = PC_WIDTH'(literal);
        pc_next    = pc + PC_WIDTH'(1);
        if (cnt_wr_en) begin
            pc_next = add_offset ? (pc + offset_ext) : target;
        end
    end

    // PC register, updated only when the sequencer retires an instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM of the 8-bit core: IDLE -> FETCH -> DECODE -> EXEC.
// Fetches an instruction, holds it for the decoder, then commits the decoder's
// enables as one-cycle write strobes and advances the PC.
// Optional feature: define SEQ_SINGLE_STEP_EN to add the step input, which runs
// exactly one instruction from IDLE per rising edge of step.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH          = PcWidthDef,
    parameter int unsigned PROGRAM_DataWidth = ProgramWidthDef,
    parameter int unsigned ParamBits         = ParamBitsDef,
    parameter int unsigned RetireBits        = RetireBitsDef
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                         step,
`endif
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic                         imem_ack,
    input  logic [PROGRAM_DataWidth-1:0] imem_rdata,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    input  logic                         dec_wr_en,
    input  logic                         dec_stat_wr_en,
    input  logic                         dec_cnt_wr_en,
    input  logic                         dec_add_offset,
    input  logic [ParamBits-1:0]         dec_literal_adr,
    output logic                         rf_wr_strobe,
    output logic                         stat_wr_strobe,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         halted,
    output logic [RetireBits-1:0]        retire_cnt
);

    seq_state_e state;
    logic       start;
    logic       pc_load;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;

    // Remember previous step level so a held step runs only one instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign start = run | (step & ~step_q);
`else
    assign start = run;
`endif

    assign pc_load   = (state == EXEC);
    assign imem_addr = pc;

    pc_unit #(
        .PC_WIDTH  (PC_WIDTH),
        .ParamBits (ParamBits)
    ) u_pc_unit (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .cnt_wr_en  (dec_cnt_wr_en),
        .add_offset (dec_add_offset),
        .literal    (dec_literal_adr),
        .pc         (pc)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            instruction    <= '0;
            imem_req       <= 1'b0;
            rf_wr_strobe   <= 1'b0;
            stat_wr_strobe <= 1'b0;
            halted         <= 1'b1;
            retire_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                FETCH: begin
                    // Fetch is never aborted; run is only consulted after EXEC
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        imem_req    <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    // Decoder has settled on the instruction; strobes go out in EXEC
                    state          <= EXEC;
                    rf_wr_strobe   <= dec_wr_en;
                    stat_wr_strobe <= dec_stat_wr_en;
                end
                EXEC: begin
                    rf_wr_strobe   <= 1'b0;
                    stat_wr_strobe <= 1'b0;
                    if (retire_cnt != '1) begin
                        retire_cnt <= retire_cnt + RetireBits'(1);
                    end
                    if (run) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. The bench plays program memory and
// decoder (enables taken from fixed bit positions of the instruction word) and
// keeps a transaction-level model of PC, retire count and strobe timing.
// A second instance with a 4-bit retire counter exercises saturation.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en, dec_add_offset;
    logic [7:0]  dec_literal_adr;
    logic        imem_req, rf_wr_strobe, stat_wr_strobe, halted;
    logic [7:0]  imem_addr, pc;
    logic [15:0] instruction, retire_cnt;
    logic        s_imem_req, s_rf, s_stat, s_halted;
    logic [7:0]  s_imem_addr, s_pc;
    logic [15:0] s_instruction;
    logic [3:0]  s_retire_cnt;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step            (step),
`endif
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .dec_wr_en       (dec_wr_en),
        .dec_stat_wr_en  (dec_stat_wr_en),
        .dec_cnt_wr_en   (dec_cnt_wr_en),
        .dec_add_offset  (dec_add_offset),
        .dec_literal_adr (dec_literal_adr),
        .rf_wr_strobe    (rf_wr_strobe),
        .stat_wr_strobe  (stat_wr_strobe),
        .pc              (pc),
        .halted          (halted),
        .retire_cnt      (retire_cnt)
    );

    cpu_sequencer #(.RetireBits(4)) dut_sat (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step            (step),
`endif
        .imem_req        (s_imem_req),
        .imem_addr       (s_imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instruction     (s_instruction),
        .dec_wr_en       (dec_wr_en),
        .dec_stat_wr_en  (dec_stat_wr_en),
        .dec_cnt_wr_en   (dec_cnt_wr_en),
        .dec_add_offset  (dec_add_offset),
        .dec_literal_adr (dec_literal_adr),
        .rf_wr_strobe    (s_rf),
        .stat_wr_strobe  (s_stat),
        .pc              (s_pc),
        .halted          (s_halted),
        .retire_cnt      (s_retire_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] mem [256];
    int          ack_delay = 0;
    bit          rand_delay = 0;

    // Model state
    logic [7:0]  mpc = 8'h00;
    int          mret = 0;
    int          msat = 0;
    int          ph = 0;
    logic [15:0] cur_word = 16'h0;
    bit          run_at = 1'b0;
    logic        last_rf = 1'b0, last_stat = 1'b0;
    int          last_exec_cyc = -1;
    int          exec_gap = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Next PC from the instruction word, plain modular arithmetic
    function automatic logic [7:0] model_next_pc(input logic [7:0] p, input logic [15:0] w);
        int s;
        if (w[13] && !w[12]) return w[7:0];
        if (w[13] && w[12]) begin
            s = (int'(w[7:0]) >= 128) ? int'(w[7:0]) - 256 : int'(w[7:0]);
            return 8'((int'(p) + s + 256) % 256);
        end
        return 8'((int'(p) + 1) % 256);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Program memory + decoder stand-in
    initial begin
        int wcnt = 0;
        int cur_delay = 0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        {dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en, dec_add_offset} = '0;
        dec_literal_adr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req === 1'b1) begin
                if (wcnt == 0) cur_delay = rand_delay ? $urandom_range(0, 3) : ack_delay;
                if (wcnt >= cur_delay) begin
                    imem_ack        = 1'b1;
                    imem_rdata      = mem[imem_addr];
                    dec_wr_en       = imem_rdata[15];
                    dec_stat_wr_en  = imem_rdata[14];
                    dec_cnt_wr_en   = imem_rdata[13];
                    dec_add_offset  = imem_rdata[12];
                    dec_literal_adr = imem_rdata[7:0];
                end else begin
                    imem_ack = 1'b0;
                end
                wcnt++;
            end else begin
                imem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: follows each instruction from accepted fetch to retirement
    initial forever begin
        @(negedge clk);
        if (reset === 1'b1) begin
            mpc = 8'h00; mret = 0; msat = 0; ph = 0;
            chk("rst_halted", halted, 1);
            chk("rst_pc", pc, 0);
            chk("rst_req", imem_req, 0);
            chk("rst_strobes", {rf_wr_strobe, stat_wr_strobe}, 0);
            chk("rst_instr", instruction, 0);
            chk("rst_retire", retire_cnt, 0);
        end else if (ph == 1) begin
            chk("decode_instr", instruction, cur_word);
            chk("decode_strobes", {rf_wr_strobe, stat_wr_strobe}, 0);
            chk("decode_req", imem_req, 0);
            ph = 2;
        end else if (ph == 2) begin
            chk("exec_rf_strobe", rf_wr_strobe, cur_word[15]);
            chk("exec_stat_strobe", stat_wr_strobe, cur_word[14]);
            chk("exec_pc", pc, mpc);
            last_rf = rf_wr_strobe;
            last_stat = stat_wr_strobe;
            mpc = model_next_pc(mpc, cur_word);
            mret = (mret < 65535) ? mret + 1 : 65535;
            msat = (msat < 15) ? msat + 1 : 15;
            run_at = run;
            if (last_exec_cyc >= 0) exec_gap = cyc - last_exec_cyc;
            last_exec_cyc = cyc;
            ph = 3;
        end else begin
            if (ph == 3) begin
                chk("next_pc", pc, mpc);
                chk("retire_cnt", retire_cnt, mret);
                chk("retire_sat", s_retire_cnt, msat);
                chk("halted_after_exec", halted, !run_at);
                chk("req_after_exec", imem_req, run_at);
                ph = 0;
            end
            chk("idle_strobes", {rf_wr_strobe, stat_wr_strobe}, 0);
            if (imem_req === 1'b1) begin
                chk("fetch_addr", imem_addr, mpc);
                if (imem_ack === 1'b1) begin
                    cur_word = mem[mpc];
                    ph = 1;
                end
            end
        end
    end

    task automatic set_run(input logic v);
        @(posedge clk);
        #2 run = v;
    endtask

    task automatic wait_req(input int maxc);
        int n = 0;
        while (imem_req !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_req_timeout", (n < maxc), 1);
    endtask

    task automatic wait_halted(input int maxc);
        int n = 0;
        while (halted !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_halt_timeout", (n < maxc), 1);
    endtask

    // Run exactly one instruction by pulsing run around the fetch
    task automatic exec_one();
        set_run(1'b1);
        wait_req(20);
        set_run(1'b0);
        wait_halted(40);
    endtask

    typedef struct {
        logic [7:0]  setup;
        logic [15:0] word;
        logic [7:0]  exp_pc;
        logic        exp_rf;
        logic        exp_stat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1;
        run   = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Idle after reset with run low
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_halted", halted, 1);
            chk("idle_pc", pc, 0);
            chk("idle_req", imem_req, 0);
        end

        // Back-to-back ADD, SUB, NOP with immediate ack
        mem[0] = 16'hC212;
        mem[1] = 16'hC312;
        mem[2] = 16'h0000;
        last_exec_cyc = -1;
        set_run(1'b1);
        n = 0;
        while (mret < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("two_instr_timeout", (n < 50), 1);
        set_run(1'b0);
        wait_halted(40);
        chk("exec_period", exec_gap, 3);
        chk("pc_after_three", pc, 3);

        // Delayed ack with run dropped while waiting
        ack_delay = 4;
        mem[3] = 16'h8400;
        set_run(1'b1);
        wait_req(20);
        set_run(1'b0);
        repeat (2) @(negedge clk);
        chk("addr_held", imem_addr, 3);
        wait_halted(40);
        chk("slow_retire", retire_cnt, 4);
        chk("slow_pc", pc, 4);
        ack_delay = 0;

        // Single-instruction vectors
        vecs[0]  = '{8'h05, 16'h273F, 8'h3F, 1'b0, 1'b0};
        vecs[1]  = '{8'h10, 16'h3BFE, 8'h0E, 1'b0, 1'b0};
        vecs[2]  = '{8'hFF, 16'h0000, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{8'h02, 16'h3BFE, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{8'h7F, 16'h3B01, 8'h80, 1'b0, 1'b0};
        vecs[5]  = '{8'h80, 16'h3B80, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'h20, 16'h0F55, 8'h21, 1'b0, 1'b0};
        vecs[7]  = '{8'h30, 16'h8100, 8'h31, 1'b1, 1'b0};
        vecs[8]  = '{8'h31, 16'h4200, 8'h32, 1'b0, 1'b1};
        vecs[9]  = '{8'h40, 16'h1C05, 8'h41, 1'b0, 1'b0};
        vecs[10] = '{8'h50, 16'hF802, 8'h52, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            if (mpc != vecs[i].setup) begin
                mem[mpc] = 16'h2700 | {8'h00, vecs[i].setup};
                exec_one();
            end
            mem[vecs[i].setup] = vecs[i].word;
            exec_one();
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_rf", i), last_rf, vecs[i].exp_rf);
            chk($sformatf("vec%0d_stat", i), last_stat, vecs[i].exp_stat);
        end

        // Reset while EXEC strobe is high
        mem[mpc] = 16'hC000;
        set_run(1'b1);
        n = 0;
        while (rf_wr_strobe !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_wait_timeout", (n < 20), 1);
        #1 reset = 1'b1;
        run = 1'b0;
        #1;
        chk("midrst_strobes", {rf_wr_strobe, stat_wr_strobe}, 0);
        chk("midrst_pc", pc, 0);
        chk("midrst_halted", halted, 1);
        chk("midrst_req", imem_req, 0);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;

        // Random program, random ack latency, mostly running
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        rand_delay = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2 run = ($urandom_range(0, 9) != 0);
        end
        set_run(1'b0);
        wait_halted(40);
        rand_delay = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
        begin
            int r0;
            logic [7:0] p0;
            repeat (3) @(negedge clk);
            r0 = mret;
            p0 = mpc;
            mem[p0] = 16'h0000;
            mem[8'(p0 + 8'd1)] = 16'h0000;
            @(posedge clk);
            #2 step = 1'b1;
            @(posedge clk);
            #2 step = 1'b0;
            repeat (10) @(negedge clk);
            chk("step_retire", retire_cnt, 16'(r0 + 1));
            chk("step_pc", pc, 8'(p0 + 8'd1));
            chk("step_halted", halted, 1);
            @(posedge clk);
            #2 step = 1'b1;
            repeat (20) @(negedge clk);
            chk("step_held_retire", retire_cnt, 16'(r0 + 2));
            chk("step_held_halted", halted, 1);
            @(posedge clk);
            #2 step = 1'b0;
            repeat (3) @(negedge clk);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
